serial_add_sequencer: RTL and testbench
=======================================

// Module: serial_add_sequencer
// PURPOSE
//  Bit-serial add/subtract unit for the SAP-U ALU path.
//  One full_adder instance is time-shared over WIDTH clock cycles, LSB first,
//  with a registered carry between cycles. Contains the FSM, operand shift
//  registers, bit counter, start/busy/done handshake and flag generation.
//  Trades latency for area against a ripple adder of WIDTH full_adders.
// PARAMETERS
//  WIDTH   8   operand/result width in bits (>=2)
//  CNT_W   $clog2(WIDTH+1)   bit-counter width (derived, not overridden)
// PORTS
//  clk       in   1      system clock, all state updates on rising edge
//  rst       in   1      asynchronous, active-high reset
//  start     in   1      request: sample a, b, sub when accepted
//  sub       in   1      0: a+b   1: a-b (two's complement)
//  a         in   WIDTH  operand A
//  b         in   WIDTH  operand B
//  busy      out  1      high while an operation is in progress (SHIFT state)
//  done      out  1      one-cycle pulse: result/flags valid
//  result    out  WIDTH  sum/difference, held until next accepted start
//  cout      out  1      carry out of MSB (sub: 1 = no borrow)
//  overflow  out  1      signed overflow: carry into MSB XOR carry out of MSB
//  zero      out  1      result == 0
// BEHAVIOUR
//  Reset (async, any state): FSM->IDLE. busy, done, result, cout, overflow,
//   zero, carry reg, counter, shift regs all 0.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE: start=1 at rising edge -> accepted. Load sr_a<=a,
//   sr_b<=sub ? ~b : b, carry<=sub, cnt<=0, state->SHIFT.
//  SHIFT: busy=1. Each edge: full_adder(sr_a[0], sr_b[0], carry) ->
//   sr_r<={s, sr_r[WIDTH-1:1]}, carry<=cout_fa, sr_a/sr_b >>1, cnt<=cnt+1.
//   On the cycle cnt==WIDTH-1, also capture carry-in of that bit
//   (the MSB) for overflow. After WIDTH shift edges -> DONE.
//  DONE: exactly one cycle. done=1, busy=0. result/cout/overflow/zero updated
//   on the edge entering DONE and held stable until the next accepted start.
//   Next edge -> IDLE, or -> SHIFT if start=1 (back-to-back accept allowed).
//  Latency: start accepted at edge E -> done high in cycle after edge E+WIDTH;
//   next operation can be accepted at edge E+WIDTH+1.
//  start while busy=1: ignored, not queued; operands in flight unaffected.
//  Changes on a, b, sub after acceptance have no effect.
//  Arithmetic mod 2^WIDTH; sub is a + ~b + 1. cout on sub = 1 when a >= b
//   unsigned. overflow uses signed interpretation for both add and sub.
//  Reset mid-operation: abort immediately, no done pulse, outputs to 0.
//  Outputs are registered; no combinational path from inputs to outputs.
// TESTING (WIDTH=8)
//  T1 add 0x3C+0x42 -> done at edge E+8, result=0x7E cout=0 ovf=0 zero=0;
//   busy high exactly 8 cycles.
//  T2 add 0x7F+0x01 -> 0x80 cout=0 ovf=1; add 0xFF+0x01 -> 0x00 cout=1
//   ovf=0 zero=1.
//  T3 sub 0x05-0x07 -> 0xFE cout=0 ovf=0; sub 0x80-0x01 -> 0x7F cout=1
//   ovf=1; sub 0x42-0x42 -> 0x00 cout=1 zero=1.
//  T4 start pulsed with a=0x11 b=0x22 in SHIFT cycle 3 of op 0x10+0x01
//   -> ignored, result=0x11, only one done pulse.
//  T5 start held high in DONE cycle with 0x01+0x01 -> accepted, no IDLE
//   cycle, second done 9 cycles after first, result=0x02.
//  T6 rst asserted mid-SHIFT (cycle 4) -> all outputs 0 asynchronously,
//   no done; after release new op 0xAA+0x55 -> 0xFF cout=0.

Source files
------------

// File: rtl/serial_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_add_sequencer (with helper full_adder)
//  Description : Bit-serial add/subtract unit. A single full adder is reused
//                over WIDTH clock cycles, LSB first, with a registered carry
//                between cycles. start/busy/done handshake, result and
//                carry/overflow/zero flags.
//  Ports       : clk, rst (async, active-high)
//                start, sub, a[WIDTH], b[WIDTH]          -> inputs
//                busy, done, result[WIDTH], cout,
//                overflow, zero                          -> outputs
//  Revision    : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  full_adder : one-bit full adder, purely combinational.
// ----------------------------------------------------------------------------
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// ----------------------------------------------------------------------------
//  serial_add_sequencer : top level.
// ----------------------------------------------------------------------------
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_accept;

    logic [WIDTH-1:0] r_sr_a;      // operand A, refilled with sum bits from the top
    logic [WIDTH-1:0] r_sr_b;      // operand B (already inverted for subtract)
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_fa_s;
    logic             w_fa_cout;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;

    full_adder u_fa (
        .i_a    (r_sr_a[0]),
        .i_b    (r_sr_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_fa_s),
        .o_cout (w_fa_cout)
    );

    assign w_last = (r_cnt == c_last_cnt);

    // The A register doubles as the result shift register: each consumed LSB
    // is replaced by the new sum bit entering at the MSB, so after WIDTH
    // shifts it holds the complete sum.
    assign w_sum_next = {w_fa_s, r_sr_a[WIDTH-1:1]};

    // Both status outputs decode the state register only.
    assign busy = (r_state == ST_SHIFT);
    assign done = (r_state == ST_DONE);

    // ------------------------------------------------------------------
    //  State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    //  Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // start is deliberately ignored here
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    //  Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sr_a   <= '0;
            r_sr_b   <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else if (w_accept) begin
            // Subtract as a + ~b + 1: the +1 enters as the initial carry.
            r_sr_a  <= a;
            r_sr_b  <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_sr_a  <= w_sum_next;
            r_sr_b  <= {1'b0, r_sr_b[WIDTH-1:1]};
            r_carry <= w_fa_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                // r_carry is the carry into the MSB during this final bit.
                result   <= w_sum_next;
                cout     <= w_fa_cout;
                overflow <= r_carry ^ w_fa_cout;
                zero     <= (w_sum_next == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_add_sequencer
//  Description : Self-checking bench for serial_add_sequencer (WIDTH=8).
//                Directed cases plus random operations compared against an
//                integer-arithmetic reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_sequencer;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    int n_assert = 0;
    int n_fail   = 0;

    // expected values for the operation in flight
    logic [WIDTH-1:0] exp_r;
    logic             exp_c;
    logic             exp_v;
    logic             exp_z;

    serial_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic os);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(oa);
        ub = int'(ob);
        sa = int'($signed(oa));
        sb = int'($signed(ob));
        ur = os ? (ua - ub) : (ua + ub);
        sr = os ? (sa - sb) : (sa + sb);
        exp_r = ur[WIDTH-1:0];
        exp_c = os ? (ua >= ub) : (ur >= 256);
        exp_v = (sr > 127) || (sr < -128);
        exp_z = (exp_r == '0);
    endtask

    // Called at a negedge: present an operation, let the next edge accept it,
    // then scramble the inputs to show they are not resampled.
    task automatic start_op(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob, input logic os);
        model(oa, ob, os);
        a = oa; b = ob; sub = os; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        sub = 1'($urandom);
    endtask

    // Entered at the first negedge after acceptance. Optionally pulses a
    // spurious start at busy cycle 'inject'. Returns at the negedge in DONE.
    task automatic wait_done(input string tag, input int inject);
        int k, nb;
        k = 1;
        nb = 0;
        while (!done && k <= 20) begin
            if (busy) nb++;
            if (k == inject) begin
                start = 1'b1; a = 8'h11; b = 8'h22; sub = 1'b0;
            end else if (k == inject + 1) begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check({tag, ".done_seen"}, 32'(done), 32'd1);
        check({tag, ".latency"},   32'(k), 32'(WIDTH + 1));
        check({tag, ".busy_cyc"},  32'(nb), 32'(WIDTH));
        check({tag, ".busy_done"}, 32'(busy), 32'd0);
        check({tag, ".result"},    32'(result), 32'(exp_r));
        check({tag, ".cout"},      32'(cout), 32'(exp_c));
        check({tag, ".ovf"},       32'(overflow), 32'(exp_v));
        check({tag, ".zero"},      32'(zero), 32'(exp_z));
    endtask

    // One cycle after DONE: pulse over, back in IDLE, outputs held.
    task automatic check_after(input string tag);
        @(negedge clk);
        check({tag, ".done_1cyc"}, 32'(done), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
        check({tag, ".held"},      32'(result), 32'(exp_r));
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #1;
        check("reset.busy",   32'(busy), 32'd0);
        check("reset.done",   32'(done), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.flags",  32'({cout, overflow, zero}), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // T1..T3 directed arithmetic
        start_op(8'h3C, 8'h42, 1'b0); wait_done("t1_add", 0);     check_after("t1");
        start_op(8'h7F, 8'h01, 1'b0); wait_done("t2_ovf", 0);     check_after("t2a");
        start_op(8'hFF, 8'h01, 1'b0); wait_done("t2_wrap", 0);    check_after("t2b");
        start_op(8'h05, 8'h07, 1'b1); wait_done("t3_borrow", 0);  check_after("t3a");
        start_op(8'h80, 8'h01, 1'b1); wait_done("t3_sovf", 0);    check_after("t3b");
        start_op(8'h42, 8'h42, 1'b1); wait_done("t3_zero", 0);    check_after("t3c");

        // T4: start pulsed during SHIFT cycle 3 is ignored
        start_op(8'h10, 8'h01, 1'b0); wait_done("t4_ignore", 3);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t4.extra_done", 32'(ndone), 32'd0);
        check("t4.result", 32'(result), 32'h11);

        // T5: start held during DONE -> back-to-back accept
        start_op(8'h20, 8'h03, 1'b0); wait_done("t5_first", 0);
        start_op(8'h01, 8'h01, 1'b0);
        check("t5.no_idle", 32'(busy), 32'd1);
        wait_done("t5_second", 1000);
        check_after("t5");

        // T6: reset mid-SHIFT aborts asynchronously
        model(8'h0F, 8'h0F, 1'b0);
        a = 8'h0F; b = 8'h0F; sub = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 1; i < 4; i++) @(negedge clk);
        check("t6.busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6.busy",   32'(busy), 32'd0);
        check("t6.done",   32'(done), 32'd0);
        check("t6.result", 32'(result), 32'd0);
        check("t6.flags",  32'({cout, overflow, zero}), 32'd0);
        @(negedge clk); rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t6.no_done", 32'(ndone), 32'd0);
        start_op(8'hAA, 8'h55, 1'b0); wait_done("t6_after", 0); check_after("t6");

        // Random operations, some back-to-back
        for (int i = 0; i < 30; i++) begin
            start_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
            wait_done($sformatf("rnd%0d", i), 0);
            if ($urandom_range(1, 0) == 0) check_after($sformatf("rnd%0d", i));
        end
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
